// File: rtl/result_display.sv
`default_nettype none
// ============================================================================
//  Module      : result_display
//  Description : Captures a 32-bit result and its error flag, converts the
//                value to 10 BCD digits with a sequential shift-add-3 engine
//                (one iteration per clock), and scans the digits onto a
//                time-multiplexed seven-segment display.
//                Optional leading-zero blanking: define RESULT_DISPLAY_LZB_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module result_display #(
    parameter int RESULT_W = 32,
    parameter int DIGITS   = 10,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [RESULT_W-1:0]   result,
    input  logic                  error,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int ITER_W = $clog2(RESULT_W);
    localparam int CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_DISPLAY = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [RESULT_W-1:0] shift_q;
    logic [BCD_W-1:0]    scratch_q;
    logic [ITER_W-1:0]   iter_q;
    logic                err_q;       // error flag of the conversion in flight
    logic                disp_err_q;  // error flag of the value being shown
    logic [BCD_W-1:0]    bcd_q;
    logic                bcd_valid_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    idx_q;
    logic [6:0]          seg_q;
    logic [DIGITS-1:0]   an_q;

    logic                load_fire, last_iter;
    logic [BCD_W-1:0]    adj, scratch_nx, bcd_nx;
    logic [RESULT_W-1:0] shift_nx;
    logic                valid_nx, derr_nx;
    logic [CNT_W-1:0]    cnt_nx;
    logic [IDX_W-1:0]    idx_nx;
    logic [3:0]          digit_nx;
    logic [6:0]          seg_nx;
    logic [DIGITS-1:0]   an_nx;
`ifdef RESULT_DISPLAY_LZB_EN
    logic [DIGITS-1:0]   lz;
    logic                zero_above;
`endif

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and handshake outputs
    always_comb begin
        state_d    = state_q;
        load_ready = (state_q != S_CONVERT);
        busy       = (state_q == S_CONVERT);
        load_fire  = load_valid && load_ready;
        last_iter  = (state_q == S_CONVERT) && (iter_q == ITER_W'(RESULT_W - 1));
        case (state_q)
            S_IDLE, S_DISPLAY: if (load_fire) state_d = S_CONVERT;
            S_CONVERT:         if (last_iter) state_d = S_DISPLAY;
            default:           state_d = S_IDLE;
        endcase
    end

    // One double-dabble iteration: add 3 to digits >= 5, then shift left
    always_comb begin
        adj = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
        end
        scratch_nx = {adj[BCD_W-2:0], shift_q[RESULT_W-1]};
        shift_nx   = {shift_q[RESULT_W-2:0], 1'b0};
    end

    // Next display contents; the completing value is shown on the same edge
    always_comb begin
        bcd_nx   = last_iter ? scratch_nx : bcd_q;
        valid_nx = bcd_valid_q | last_iter;
        derr_nx  = last_iter ? err_q : disp_err_q;
        cnt_nx   = cnt_q;
        idx_nx   = idx_q;
        if (bcd_valid_q) begin
            if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                cnt_nx = '0;
                idx_nx = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_nx = cnt_q + 1'b1;
            end
        end
        digit_nx = bcd_nx[4*idx_nx +: 4];
`ifdef RESULT_DISPLAY_LZB_EN
        // lz[k] set when digit k and every digit above it are zero (never digit 0)
        lz         = '0;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (bcd_nx[4*k +: 4] != 4'd0) zero_above = 1'b0;
            lz[k] = zero_above;
        end
`endif
        an_nx  = valid_nx ? (DIGITS'(1) << idx_nx) : '0;
        seg_nx = 7'h00;
        if (valid_nx) begin
            if (derr_nx) begin
                seg_nx = (idx_nx == '0) ? 7'h79 : 7'h00;
            end else begin
`ifdef RESULT_DISPLAY_LZB_EN
                seg_nx = lz[idx_nx] ? 7'h00 : seg_of(digit_nx);
`else
                seg_nx = seg_of(digit_nx);
`endif
            end
        end
    end

    // Conversion datapath, result registers and scan registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            scratch_q   <= '0;
            iter_q      <= '0;
            err_q       <= 1'b0;
            disp_err_q  <= 1'b0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            cnt_q       <= '0;
            idx_q       <= '0;
            seg_q       <= '0;
            an_q        <= '0;
        end else begin
            if (load_fire) begin
                shift_q   <= result;
                err_q     <= error;
                scratch_q <= '0;
                iter_q    <= '0;
            end else if (state_q == S_CONVERT) begin
                shift_q   <= shift_nx;
                scratch_q <= scratch_nx;
                iter_q    <= iter_q + 1'b1;
            end
            bcd_q       <= bcd_nx;
            bcd_valid_q <= valid_nx;
            disp_err_q  <= derr_nx;
            cnt_q       <= cnt_nx;
            idx_q       <= idx_nx;
            seg_q       <= seg_nx;
            an_q        <= an_nx;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule
`default_nettype wire

// File: tb/tb_result_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_display
//  Description : Self-checking bench for result_display (SCAN_DIV = 4).
//                Expected digits come from decimal arithmetic on the loaded
//                value; expected segments from the digit table.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_result_display;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [31:0] result = '0;
    logic        error = 1'b0;
    logic        busy;
    logic [39:0] bcd;
    logic        bcd_valid;
    logic [6:0]  seg;
    logic [9:0]  an;

    int n_cmp = 0;
    int n_err = 0;

    // displayed (current) and pending model state
    logic [39:0] cur_bcd = '0, pend_bcd;
    logic [6:0]  cur_seg [10];
    logic [6:0]  pend_seg [10];
    logic        cur_valid = 1'b0;
    logic [9:0]  last_an = '0;
    logic [9:0]  seen = '0;
    int          run = 0;
    bit          run_known = 0;

    result_display #(.RESULT_W(32), .DIGITS(10), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
        .result(result), .error(error), .busy(busy), .bcd(bcd),
        .bcd_valid(bcd_valid), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] enc(input int d);
        logic [6:0] t [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        return t[d];
    endfunction

    // Build expected bcd and per-position segments for a value/error pair
    task automatic model(input logic [31:0] v, input logic e);
        longint x = v;
        int     dig [10];
        int     msd = 0;
        for (int k = 0; k < 10; k++) begin
            dig[k] = int'(x % 10);
            x      = x / 10;
            pend_bcd[4*k +: 4] = 4'(dig[k]);
            if (dig[k] != 0) msd = k;
        end
        for (int k = 0; k < 10; k++) begin
            if (e)             pend_seg[k] = (k == 0) ? 7'h79 : 7'h00;
`ifdef RESULT_DISPLAY_LZB_EN
            else if (k > msd)  pend_seg[k] = 7'h00;
`endif
            else               pend_seg[k] = enc(dig[k]);
        end
    endtask

    // Check the scanned display against the currently shown value
    task automatic check_disp();
        int p = 0;
        if (!cur_valid) begin
            chk("an_blank", 64'(an), 64'd0);
            chk("seg_blank", 64'(seg), 64'd0);
            return;
        end
        chk("an_onehot", 64'($onehot(an)), 64'd1);
        for (int k = 0; k < 10; k++) if (an[k]) p = k;
        seen[p] = 1'b1;
        chk($sformatf("seg_digit%0d", p), 64'(seg), 64'(cur_seg[p]));
        if (an != last_an) begin
            if (last_an != '0) begin
                chk("an_advance", 64'(an), 64'({last_an[8:0], last_an[9]}));
                if (run_known) chk("scan_dwell", 64'(run), 64'(SD));
                run_known = 1;
            end
            run = 1;
            last_an = an;
        end else begin
            run++;
        end
    endtask

    task automatic reset_model();
        cur_valid = 0; cur_bcd = '0; last_an = '0; run = 0; run_known = 0;
    endtask

    // Load a value and follow the conversion; optional ignored pulse / reset
    task automatic run_load(input logic [31:0] v, input logic e,
                            input int inject_at, input int reset_at);
        model(v, e);
        @(negedge clk);
        load_valid = 1'b1; result = v; error = e;
        chk("load_ready_idle", 64'(load_ready), 64'd1);
        @(posedge clk); #1;
        load_valid = 1'b0; result = $urandom; error = 1'($urandom);
        chk("busy_start", 64'(busy), 64'd1);
        check_disp();
        for (int i = 1; i < 32; i++) begin
            if (i == inject_at) begin
                load_valid = 1'b1; result = 32'd5; error = 1'b0;
                chk("load_ready_conv", 64'(load_ready), 64'd0);
            end
            @(posedge clk); #1;
            load_valid = 1'b0;
            chk("busy_conv", 64'(busy), 64'd1);
            chk("valid_conv", 64'(bcd_valid), 64'(cur_valid));
            chk("bcd_hold", 64'(bcd), 64'(cur_bcd));
            check_disp();
            if (i == reset_at) begin
                #2 rst_n = 1'b0;
                #1;
                reset_model();
                chk("rst_busy", 64'(busy), 64'd0);
                chk("rst_valid", 64'(bcd_valid), 64'd0);
                chk("rst_an", 64'(an), 64'd0);
                chk("rst_seg", 64'(seg), 64'd0);
                chk("rst_bcd", 64'(bcd), 64'd0);
                chk("rst_ready", 64'(load_ready), 64'd1);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        @(posedge clk); #1;
        chk("busy_done", 64'(busy), 64'd0);
        chk("valid_done", 64'(bcd_valid), 64'd1);
        chk("bcd_done", 64'(bcd), 64'(pend_bcd));
        cur_valid = 1; cur_bcd = pend_bcd; cur_seg = pend_seg; seen = '0;
        check_disp();
        repeat (10 * SD + 3) begin
            @(posedge clk); #1;
            check_disp();
        end
        chk("all_digits_seen", 64'(seen), 64'h3FF);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_seg", 64'(seg), 64'd0);
        chk("reset_an", 64'(an), 64'd0);
        chk("reset_ready", 64'(load_ready), 64'd1);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(bcd_valid), 64'd0);
        chk("reset_bcd", 64'(bcd), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_load(32'd48000, 1'b0, -1, -1);
        chk("bcd_48000", 64'(bcd), 64'h0000048000);
        run_load(32'hFFFF_FFFF, 1'b0, -1, -1);
        chk("bcd_max", 64'(bcd), 64'h4294967295);
        run_load(32'd16000, 1'b1, -1, -1);
        chk("bcd_err", 64'(bcd), 64'h0000016000);
        run_load(32'd0, 1'b0, -1, -1);
        run_load($urandom, 1'b0, 10, -1);
        run_load(32'd123456, 1'b0, -1, 17);
        run_load(32'd7, 1'b0, -1, -1);
        chk("bcd_7", 64'(bcd), 64'h7);
        repeat (6) run_load($urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 3) == 0), -1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
